flag_pipe_unit: RTL and testbench



---
 rtl/flag_pkg.sv | 37 +++
 rtl/D_FF.sv | 19 +
 rtl/cond_eval.sv | 41 ++++
 rtl/mux_2_1.sv | 15 +
 rtl/flag_pipe_unit.sv | 109 ++++++++++
 tb/tb_flag_pipe_unit.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/flag_pkg.sv
// Shared flag definitions: NZCV bit positions, AArch64 condition codes, pipeline entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flag_pkg;

    // Bit positions of the flags inside a 4-bit {N,Z,C,V} vector
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    // One in-flight flag write; data bits are meaningless when valid is low
    typedef struct packed {
        logic       valid;
        logic [3:0] flags;
    } flag_entry_t;

endpackage

// File: rtl/D_FF.sv
// Plain W-bit register, cleared by an asynchronous active-high reset.
// Latency: 1 cycle from i_d to o_q.
// Backpressure: none; hold behaviour is supplied by the caller through the D input.
module D_FF #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture D every edge; reset clears immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_q <= '0;
        else       o_q <= i_d;
    end

endmodule

// File: rtl/cond_eval.sv
// Evaluates an AArch64 condition code against an {N,Z,C,V} flag vector.
// Latency: combinational.
// Backpressure: n/a; also used by the CSEL/CSINC datapath.
module cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_cond_true
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLG_N];
    assign w_z = i_flags[FLG_Z];
    assign w_c = i_flags[FLG_C];
    assign w_v = i_flags[FLG_V];

    // Condition table; AL and NV both evaluate true
    always_comb begin
        o_cond_true = 1'b1;
        case (cond_t'(i_cond))
            COND_EQ: o_cond_true =   w_z;
            COND_NE: o_cond_true =  ~w_z;
            COND_CS: o_cond_true =   w_c;
            COND_CC: o_cond_true =  ~w_c;
            COND_MI: o_cond_true =   w_n;
            COND_PL: o_cond_true =  ~w_n;
            COND_VS: o_cond_true =   w_v;
            COND_VC: o_cond_true =  ~w_v;
            COND_HI: o_cond_true =   w_c & ~w_z;
            COND_LS: o_cond_true = ~(w_c & ~w_z);
            COND_GE: o_cond_true =  (w_n == w_v);
            COND_LT: o_cond_true =  (w_n != w_v);
            COND_GT: o_cond_true =  ~w_z & (w_n == w_v);
            COND_LE: o_cond_true = ~(~w_z & (w_n == w_v));
            default: o_cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/mux_2_1.sv
// W-bit two-input selector: i_sel=0 picks i_a, i_sel=1 picks i_b.
// Latency: combinational.
// Backpressure: n/a.
module mux_2_1 #(
    parameter int W = 1
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/flag_pipe_unit.sv
// Tracks NZCV writes through DEPTH in-flight stages, commits the oldest to arch_flags, forwards the youngest.
// Latency: write in EX at cycle t is on arch_flags after edge t+DEPTH+1; forwarding is same-cycle.
// Backpressure: stall freezes all stages and arch_flags; the EX write is not captured and must be re-presented.
module flag_pipe_unit
    import flag_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_flag_we,
    input  logic             ex_kill,
    input  logic [3:0]       ex_flags,
    input  logic [3:0]       cond,
    output logic [3:0]       fwd_flags,
    output logic             cond_true,
    output logic [3:0]       arch_flags,
    output logic             commit_valid,
    output logic [CNT_W-1:0] pending_cnt
);

    localparam int EW = $bits(flag_entry_t);

    logic        w_ex_vld;
    flag_entry_t w_ex_entry;
    flag_entry_t w_stage_d [DEPTH];
    flag_entry_t w_stage_n [DEPTH];
    flag_entry_t r_stage_q [DEPTH];
    logic [3:0]  w_arch_n;
    logic [3:0]  r_arch;
    logic [3:0]  w_fwd;
    logic [CNT_W-1:0] w_cnt;

    // Kill always wins over the write enable
    assign w_ex_vld   = ex_flag_we & ~ex_kill;
    assign w_ex_entry = {w_ex_vld, ex_flags};

    // Shift chain: s[0] loads from EX, s[i] from s[i-1]; stall recirculates each stage
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_stage_d[gi] = w_ex_entry;
        end else begin : g_body
            assign w_stage_d[gi] = r_stage_q[gi-1];
        end

        mux_2_1 #(.W(EW)) u_hold (
            .i_sel (stall),
            .i_a   (w_stage_d[gi]),
            .i_b   (r_stage_q[gi]),
            .o_y   (w_stage_n[gi])
        );

        D_FF #(.W(EW)) u_ff (
            .i_clk (clk),
            .i_rst (reset),
            .i_d   (w_stage_n[gi]),
            .o_q   (r_stage_q[gi])
        );
    end

    // Oldest stage retires into the architectural register unless stalled
    assign commit_valid = r_stage_q[DEPTH-1].valid & ~stall;

    mux_2_1 #(.W(4)) u_arch_mux (
        .i_sel (commit_valid),
        .i_a   (r_arch),
        .i_b   (r_stage_q[DEPTH-1].flags),
        .o_y   (w_arch_n)
    );

    D_FF #(.W(4)) u_arch_ff (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (w_arch_n),
        .o_q   (r_arch)
    );

    assign arch_flags = r_arch;

    // Forwarding: walk oldest to youngest so the youngest valid source overrides
    always_comb begin
        w_fwd = r_arch;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_stage_q[i].valid) w_fwd = r_stage_q[i].flags;
        end
        if (w_ex_vld) w_fwd = ex_flags;
    end

    assign fwd_flags = w_fwd;

    // Count of valid in-flight stages; the EX write is not included
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + CNT_W'(r_stage_q[i].valid);
        end
    end

    assign pending_cnt = w_cnt;

    cond_eval u_cond (
        .i_flags     (w_fwd),
        .i_cond      (cond),
        .o_cond_true (cond_true)
    );

endmodule

// File: tb/tb_flag_pipe_unit.sv
// Directed bench for flag_pipe_unit at DEPTH=2 with hand-computed expectations.
// Latency: inputs driven 1ns after each rising edge, outputs sampled 1ns later.
// Backpressure: stall exercised directly by test_stall.
module tb_flag_pipe_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       ex_flag_we;
    logic       ex_kill;
    logic [3:0] ex_flags;
    logic [3:0] cond;
    logic [3:0] fwd_flags;
    logic       cond_true;
    logic [3:0] arch_flags;
    logic       commit_valid;
    logic [1:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    flag_pipe_unit #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .ex_flag_we   (ex_flag_we),
        .ex_kill      (ex_kill),
        .ex_flags     (ex_flags),
        .cond         (cond),
        .fwd_flags    (fwd_flags),
        .cond_true    (cond_true),
        .arch_flags   (arch_flags),
        .commit_valid (commit_valid),
        .pending_cnt  (pending_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall      = 1'b0;
        ex_flag_we = 1'b0;
        ex_kill    = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ex_flags = 4'b0000;
        cond     = 4'h1;
        apply_reset();
        #1;
        checks++; if (fwd_flags !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", fwd_flags); end
        checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL reset_cond_ne got=%b exp=1", cond_true); end
        checks++; if (arch_flags !== 4'b0000) begin errors++; $display("FAIL reset_arch got=%b exp=0000", arch_flags); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", commit_valid); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_latency();
        apply_reset();
        cond       = 4'h0;
        ex_flag_we = 1'b1;
        ex_flags   = 4'b0100;
        #1;
        checks++; if (fwd_flags !== 4'b0100) begin errors++; $display("FAIL lat_c0_fwd got=%b exp=0100", fwd_flags); end
        checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL lat_c0_eq got=%b exp=1", cond_true); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL lat_c0_pending got=%0d exp=0", pending_cnt); end
        step();
        ex_flag_we = 1'b0;
        #1;
        checks++; if (pending_cnt !== 2'd1) begin errors++; $display("FAIL lat_c1_pending got=%0d exp=1", pending_cnt); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL lat_c1_commit got=%b exp=0", commit_valid); end
        checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL lat_c1_eq got=%b exp=1", cond_true); end
        step();
        #1;
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL lat_c2_commit got=%b exp=1", commit_valid); end
        checks++; if (arch_flags !== 4'b0000) begin errors++; $display("FAIL lat_c2_arch got=%b exp=0000", arch_flags); end
        step();
        #1;
        checks++; if (arch_flags !== 4'b0100) begin errors++; $display("FAIL lat_c3_arch got=%b exp=0100", arch_flags); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL lat_c3_commit got=%b exp=0", commit_valid); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL lat_c3_pending got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        ex_flag_we = 1'b1;
        ex_flags   = 4'b1000;
        #1;
        checks++; if (fwd_flags !== 4'b1000) begin errors++; $display("FAIL b2b_c0_fwd got=%b exp=1000", fwd_flags); end
        step();
        ex_flags = 4'b0010;
        #1;
        checks++; if (fwd_flags !== 4'b0010) begin errors++; $display("FAIL b2b_c1_fwd got=%b exp=0010", fwd_flags); end
        step();
        ex_flag_we = 1'b0;
        #1;
        checks++; if (fwd_flags !== 4'b0010) begin errors++; $display("FAIL b2b_c2_fwd got=%b exp=0010", fwd_flags); end
        checks++; if (pending_cnt !== 2'd2) begin errors++; $display("FAIL b2b_c2_pending got=%0d exp=2", pending_cnt); end
        step();
        #1;
        checks++; if (arch_flags !== 4'b1000) begin errors++; $display("FAIL b2b_c3_arch got=%b exp=1000", arch_flags); end
        checks++; if (fwd_flags !== 4'b0010) begin errors++; $display("FAIL b2b_c3_fwd got=%b exp=0010", fwd_flags); end
        step();
        #1;
        checks++; if (arch_flags !== 4'b0010) begin errors++; $display("FAIL b2b_c4_arch got=%b exp=0010", arch_flags); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL b2b_c4_pending got=%0d exp=0", pending_cnt); end
    endtask

    // Runs from the state left by test_back_to_back: arch_flags = 0010, pipe empty
    task automatic test_kill();
        ex_flag_we = 1'b1;
        ex_kill    = 1'b1;
        ex_flags   = 4'b1111;
        #1;
        checks++; if (fwd_flags !== 4'b0010) begin errors++; $display("FAIL kill_fwd got=%b exp=0010", fwd_flags); end
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL kill_pending cyc=%0d got=%0d exp=0", k, pending_cnt); end
            checks++; if (arch_flags !== 4'b0010) begin errors++; $display("FAIL kill_arch cyc=%0d got=%b exp=0010", k, arch_flags); end
        end
        ex_flag_we = 1'b0;
        #1;
        checks++; if (fwd_flags !== 4'b0010) begin errors++; $display("FAIL kill_only_fwd got=%b exp=0010", fwd_flags); end
        idle();
    endtask

    task automatic test_stall();
        apply_reset();
        ex_flag_we = 1'b1;
        ex_flags   = 4'b0001;
        step();
        ex_flag_we = 1'b0;
        step();
        #1;
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL stall_pre_commit got=%b exp=1", commit_valid); end
        stall      = 1'b1;
        ex_flag_we = 1'b1;
        ex_flags   = 4'b1100;
        #1;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL stall_c2_commit got=%b exp=0", commit_valid); end
        checks++; if (fwd_flags !== 4'b1100) begin errors++; $display("FAIL stall_c2_fwd got=%b exp=1100", fwd_flags); end
        checks++; if (pending_cnt !== 2'd1) begin errors++; $display("FAIL stall_c2_pending got=%0d exp=1", pending_cnt); end
        step();
        ex_flag_we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL stall_commit k=%0d got=%b exp=0", k, commit_valid); end
            checks++; if (arch_flags !== 4'b0000) begin errors++; $display("FAIL stall_arch k=%0d got=%b exp=0000", k, arch_flags); end
            checks++; if (pending_cnt !== 2'd1) begin errors++; $display("FAIL stall_pending k=%0d got=%0d exp=1", k, pending_cnt); end
            checks++; if (fwd_flags !== 4'b0001) begin errors++; $display("FAIL stall_fwd k=%0d got=%b exp=0001", k, fwd_flags); end
            step();
        end
        stall = 1'b0;
        #1;
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL stall_release_commit got=%b exp=1", commit_valid); end
        checks++; if (arch_flags !== 4'b0000) begin errors++; $display("FAIL stall_release_arch got=%b exp=0000", arch_flags); end
        step();
        #1;
        checks++; if (arch_flags !== 4'b0001) begin errors++; $display("FAIL stall_commit_arch got=%b exp=0001", arch_flags); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL stall_post_pending got=%0d exp=0", pending_cnt); end
        step();
        step();
        #1;
        checks++; if (arch_flags !== 4'b0001) begin errors++; $display("FAIL stall_late_arch got=%b exp=0001", arch_flags); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        ex_flag_we = 1'b1;
        ex_flags   = 4'b0011;
        step();
        ex_flags = 4'b1010;
        step();
        ex_flags = 4'b0101;
        step();
        ex_flag_we = 1'b0;
        #1;
        checks++; if (arch_flags !== 4'b0011) begin errors++; $display("FAIL mid_pre_arch got=%b exp=0011", arch_flags); end
        checks++; if (pending_cnt !== 2'd2) begin errors++; $display("FAIL mid_pre_pending got=%0d exp=2", pending_cnt); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (arch_flags !== 4'b0000) begin errors++; $display("FAIL mid_arch got=%b exp=0000", arch_flags); end
        checks++; if (pending_cnt !== 2'd0) begin errors++; $display("FAIL mid_pending got=%0d exp=0", pending_cnt); end
        checks++; if (fwd_flags !== 4'b0000) begin errors++; $display("FAIL mid_fwd got=%b exp=0000", fwd_flags); end
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL mid_after_commit k=%0d got=%b exp=0", k, commit_valid); end
            checks++; if (arch_flags !== 4'b0000) begin errors++; $display("FAIL mid_after_arch k=%0d got=%b exp=0000", k, arch_flags); end
            step();
        end
    endtask

    task automatic test_cond_sweep();
        logic [3:0]  fv [4];
        logic [15:0] mk [4];
        logic [15:0] m;
        fv[0] = 4'b0000; mk[0] = 16'hD6AA;
        fv[1] = 4'b1001; mk[1] = 16'hD65A;
        fv[2] = 4'b0110; mk[2] = 16'hE6A5;
        fv[3] = 4'b1111; mk[3] = 16'hE655;
        idle();
        ex_flag_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_flags = fv[i];
            m = mk[i];
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                checks++;
                if (cond_true !== m[c]) begin
                    errors++;
                    $display("FAIL cond_sweep flags=%b cond=%h got=%b exp=%b", fv[i], c[3:0], cond_true, m[c]);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        ex_flag_we = 1'b0;
        ex_kill    = 1'b0;
        ex_flags   = 4'b0000;
        cond       = 4'h0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_kill();
        test_stall();
        test_reset_midstream();
        test_cond_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
